brush_painter: RTL and testbench

BRUSH_PAINTER -- requirements
Module: brush_painter

---
 rtl/sand_pkg.sv | 29 ++
 rtl/brush_mask.sv | 37 +++
 rtl/brush_painter.sv | 132 +++++++++++++
 tb/tb_brush_painter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sand_pkg.sv
`default_nettype none
// sand_pkg: grid defaults, cell types and painter FSM states shared by the sand blocks.
package sand_pkg;

    localparam int GRID_W_DEFAULT = 640;
    localparam int GRID_H_DEFAULT = 480;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SAND  = 2'd1,
        WALL  = 2'd2,
        WATER = 2'd3
    } cell_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Square of a small signed brush offset (-3..3), result 0..9.
    function automatic logic [3:0] offset_sq(input logic signed [2:0] v);
        logic [2:0] mag;
        mag = v[2] ? 3'(-v) : 3'(v);
        return {1'b0, mag} * {1'b0, mag};
    endfunction

endpackage
`default_nettype wire

// File: rtl/brush_mask.sv
`default_nettype none
// brush_mask: combinational test of whether centre+offset lies inside the disc and on the grid.
module brush_mask
    import sand_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEFAULT,
    parameter int GRID_H = GRID_H_DEFAULT
) (
    input  logic [10:0]       cx,
    input  logic [9:0]        cy,
    input  logic signed [2:0] dx,
    input  logic signed [2:0] dy,
    input  logic [1:0]        radius,
    output logic              hit
);

    localparam logic signed [12:0] W_S = 13'(GRID_W);
    localparam logic signed [12:0] H_S = 13'(GRID_H);

    logic signed [12:0] px;
    logic signed [12:0] py;
    logic [4:0]         dist2;
    logic [3:0]         r2;
    logic               in_disc;
    logic               on_grid;

    // 13 bits keeps x+dx positive even for the largest 11-bit centre.
    assign px      = $signed({2'b00, cx}) + $signed({{10{dx[2]}}, dx});
    assign py      = $signed({3'b000, cy}) + $signed({{10{dy[2]}}, dy});
    assign dist2   = {1'b0, offset_sq(dx)} + {1'b0, offset_sq(dy)};
    assign r2      = {2'b00, radius} * {2'b00, radius};
    assign in_disc = (dist2 <= {1'b0, r2});
    assign on_grid = (px >= 13'sd0) && (px < W_S) && (py >= 13'sd0) && (py < H_S);
    assign hit     = in_disc && on_grid;

endmodule
`default_nettype wire

// File: rtl/brush_painter.sv
`default_nettype none
// brush_painter: stamps a disc of one cell type into grid memory, one write per covered cell.
module brush_painter
    import sand_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEFAULT,
    parameter int GRID_H = GRID_H_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        paint_valid,
    output logic        paint_ready,
    input  logic [10:0] paint_x,
    input  logic [9:0]  paint_y,
    input  logic [1:0]  paint_radius,
    input  logic [1:0]  paint_t,
    output logic        paint_done,
    output logic [18:0] mem_address,
    output logic [1:0]  mem_writedata,
    output logic        mem_write,
    input  logic        mem_waitrequest
);

    state_t            state;
    logic [10:0]       lat_x;
    logic [9:0]        lat_y;
    logic [1:0]        lat_r;
    cell_t             lat_t;
    logic signed [2:0] dx;
    logic signed [2:0] dy;

    logic              hit;
    logic              last;
    logic signed [2:0] r_s;
    logic signed [12:0] px;
    logic signed [12:0] py;
    logic [18:0]       addr;

    brush_mask #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_mask (
        .cx     (lat_x),
        .cy     (lat_y),
        .dx     (dx),
        .dy     (dy),
        .radius (lat_r),
        .hit    (hit)
    );

    assign r_s  = $signed({1'b0, lat_r});
    assign last = (dx == r_s) && (dy == r_s);
    assign px   = $signed({2'b00, lat_x}) + $signed({{10{dx[2]}}, dx});
    assign py   = $signed({3'b000, lat_y}) + $signed({{10{dy[2]}}, dy});
    // Only used on a hit, where px/py are known non-negative.
    assign addr = 19'(32'($unsigned(py)) * 32'(GRID_W) + 32'($unsigned(px)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            paint_ready   <= 1'b1;
            paint_done    <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            lat_x         <= '0;
            lat_y         <= '0;
            lat_r         <= '0;
            lat_t         <= EMPTY;
            dx            <= '0;
            dy            <= '0;
        end else begin
            paint_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (paint_valid && paint_ready) begin
                        lat_x       <= paint_x;
                        lat_y       <= paint_y;
                        lat_r       <= paint_radius;
                        lat_t       <= cell_t'(paint_t);
                        dx          <= -$signed({1'b0, paint_radius});
                        dy          <= -$signed({1'b0, paint_radius});
                        paint_ready <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        mem_address   <= addr;
                        mem_writedata <= lat_t;
                        mem_write     <= 1'b1;
                        state         <= WRITE;
                    end else if (last) begin
                        paint_ready <= 1'b1;
                        paint_done  <= 1'b1;
                        state       <= IDLE;
                    end else if (dx == r_s) begin
                        dx <= -r_s;
                        dy <= dy + 3'sd1;
                    end else begin
                        dx <= dx + 3'sd1;
                    end
                end
                WRITE: begin
                    if (!mem_waitrequest) begin
                        mem_write <= 1'b0;
                        if (last) begin
                            paint_ready <= 1'b1;
                            paint_done  <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            state <= SCAN;
                            if (dx == r_s) begin
                                dx <= -r_s;
                                dy <= dy + 3'sd1;
                            end else begin
                                dx <= dx + 3'sd1;
                            end
                        end
                    end
                end
                default: begin
                    mem_write   <= 1'b0;
                    paint_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_brush_painter.sv
`default_nettype none
// tb_brush_painter: table-driven brushes with a write scoreboard, plus reset-during-stall sequence.
module tb_brush_painter;
    import sand_pkg::*;

    localparam int W = 640;
    localparam int H = 480;

    logic        clock = 1'b0;
    logic        reset;
    logic        paint_valid;
    logic        paint_ready;
    logic [10:0] paint_x;
    logic [9:0]  paint_y;
    logic [1:0]  paint_radius;
    logic [1:0]  paint_t;
    logic        paint_done;
    logic [18:0] mem_address;
    logic [1:0]  mem_writedata;
    logic        mem_write;
    logic        mem_waitrequest;

    brush_painter #(.GRID_W(W), .GRID_H(H)) dut (
        .clock           (clock),
        .reset           (reset),
        .paint_valid     (paint_valid),
        .paint_ready     (paint_ready),
        .paint_x         (paint_x),
        .paint_y         (paint_y),
        .paint_radius    (paint_radius),
        .paint_t         (paint_t),
        .paint_done      (paint_done),
        .mem_address     (mem_address),
        .mem_writedata   (mem_writedata),
        .mem_write       (mem_write),
        .mem_waitrequest (mem_waitrequest)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [18:0] addr;
        logic [1:0]  data;
    } wr_t;

    typedef struct {
        int x, y, r, t, stall, hold, n_wr, first_addr;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[7];

    int n_checks = 0;
    int n_pass   = 0;
    int stall_len = 0;
    int stall_cnt = 0;
    int wr_cnt, done_cnt, first_wr_cyc, done_cyc, first_wr_addr;
    logic prev_stalled = 1'b0;
    logic prev_done    = 1'b0;
    logic [18:0] prev_addr = '0;
    logic [1:0]  prev_data = '0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: raster-order disc, clipped to the grid.
    task automatic push_expected(input int x, input int y, input int r, input int t);
        wr_t e;
        for (int yy = -r; yy <= r; yy++)
            for (int xx = -r; xx <= r; xx++)
                if (xx*xx + yy*yy <= r*r && x+xx >= 0 && x+xx < W && y+yy >= 0 && y+yy < H) begin
                    e.addr = 19'((y+yy)*W + (x+xx));
                    e.data = 2'(t);
                    exp_q.push_back(e);
                end
    endtask

    // Memory model: hold waitrequest for stall_len cycles at the start of each write.
    initial begin
        mem_waitrequest = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (mem_write === 1'b1 && stall_cnt < stall_len) begin
                mem_waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                mem_waitrequest = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    // Monitor and scoreboard consumer.
    initial begin
        wr_t e;
        forever begin
            @(negedge clock);
            if (reset === 1'b0) begin
                if (mem_write && prev_stalled)
                    check(mem_address == prev_addr && mem_writedata == prev_data,
                          "stall_hold", mem_address, prev_addr);
                if (mem_write && !mem_waitrequest) begin
                    if (wr_cnt == 0) begin
                        first_wr_cyc  = cyc;
                        first_wr_addr = int'(mem_address);
                    end
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        check(1'b0, "extra_write", mem_address, -1);
                    end else begin
                        e = exp_q.pop_front();
                        check(mem_address == e.addr, "wr_addr", mem_address, e.addr);
                        check(mem_writedata == e.data, "wr_data", mem_writedata, e.data);
                    end
                end
                if (paint_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check(paint_ready == 1'b1, "done_with_ready", paint_ready, 1);
                    check(prev_done == 1'b0, "done_one_cycle", prev_done, 0);
                end
            end
            prev_stalled = mem_write && mem_waitrequest;
            prev_addr    = mem_address;
            prev_data    = mem_writedata;
            prev_done    = paint_done;
        end
    end

    task automatic run_vec(input int i);
        vec_t v;
        int   acc;
        v = vecs[i];
        wr_cnt = 0; done_cnt = 0; first_wr_cyc = -1; done_cyc = -1; first_wr_addr = -1;
        push_expected(v.x, v.y, v.r, v.t);
        stall_len = v.stall;
        @(posedge clock); #1;
        check(paint_ready == 1'b1, "ready_idle", paint_ready, 1);
        paint_valid  = 1'b1;
        paint_x      = 11'(v.x);
        paint_y      = 10'(v.y);
        paint_radius = 2'(v.r);
        paint_t      = 2'(v.t);
        acc = cyc;
        @(posedge clock); #1;
        check(paint_ready == 1'b0, "busy_not_ready", paint_ready, 0);
        // Keep a conflicting request on the inputs while busy.
        paint_x = 11'd5; paint_y = 10'd5; paint_radius = 2'd3; paint_t = 2'd3;
        repeat (v.hold) @(posedge clock);
        #1;
        paint_valid = 1'b0;
        for (int k = 0; k < 3000 && done_cnt == 0; k++) @(posedge clock);
        repeat (4) @(posedge clock);
        #1;
        check(done_cnt == 1, "done_count", done_cnt, 1);
        check(wr_cnt == v.n_wr, "write_count", wr_cnt, v.n_wr);
        check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        if (v.n_wr > 0) check(first_wr_addr == v.first_addr, "first_addr", first_wr_addr, v.first_addr);
        if (i == 0) begin
            check(first_wr_cyc == acc + 2, "write_latency", first_wr_cyc - acc, 2);
            check(done_cyc == acc + 3, "done_latency", done_cyc - acc, 3);
        end
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{x:100, y:50,  r:0, t:1, stall:0, hold:2,  n_wr:1,  first_addr:32100};
        vecs[1] = '{x:100, y:50,  r:1, t:2, stall:0, hold:2,  n_wr:5,  first_addr:31460};
        vecs[2] = '{x:0,   y:0,   r:1, t:3, stall:0, hold:2,  n_wr:3,  first_addr:0};
        vecs[3] = '{x:320, y:240, r:3, t:2, stall:4, hold:10, n_wr:29, first_addr:152000};
        vecs[4] = '{x:700, y:10,  r:2, t:1, stall:0, hold:2,  n_wr:0,  first_addr:-1};
        vecs[5] = '{x:200, y:200, r:2, t:0, stall:0, hold:2,  n_wr:13, first_addr:126920};
        vecs[6] = '{x:639, y:479, r:2, t:1, stall:1, hold:2,  n_wr:6,  first_addr:305919};

        reset = 1'b1; paint_valid = 1'b0;
        paint_x = '0; paint_y = '0; paint_radius = '0; paint_t = '0;
        wr_cnt = 0; done_cnt = 0;
        repeat (3) @(posedge clock);
        #1;
        check(paint_ready == 1'b1, "rst_ready", paint_ready, 1);
        check(paint_done == 1'b0, "rst_done", paint_done, 0);
        check(mem_write == 1'b0, "rst_write", mem_write, 0);
        check(mem_address == 19'd0, "rst_addr", mem_address, 0);
        check(mem_writedata == 2'd0, "rst_data", mem_writedata, 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i);

        // Reset while a write is stalled.
        exp_q.delete();
        wr_cnt = 0; done_cnt = 0;
        stall_len = 1000;
        @(posedge clock); #1;
        paint_valid = 1'b1; paint_x = 11'd320; paint_y = 10'd240; paint_radius = 2'd1; paint_t = 2'd1;
        @(posedge clock); #1;
        paint_valid = 1'b0;
        for (int k = 0; k < 50 && mem_write !== 1'b1; k++) begin
            @(posedge clock); #1;
        end
        repeat (2) @(posedge clock);
        #1;
        check(mem_write == 1'b1 && mem_waitrequest == 1'b1, "stall_reached", mem_write, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        check(mem_write == 1'b0, "rst_mid_write", mem_write, 0);
        check(paint_ready == 1'b1, "rst_mid_ready", paint_ready, 1);
        check(paint_done == 1'b0, "rst_mid_done", paint_done, 0);
        reset = 1'b0;
        stall_len = 0;
        repeat (20) @(posedge clock);
        #1;
        check(done_cnt == 0, "no_done_after_abort", done_cnt, 0);
        check(wr_cnt == 0, "no_write_after_abort", wr_cnt, 0);
        check(paint_ready == 1'b1, "idle_after_abort", paint_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
